// File: rtl/tone_sequencer.sv
// -----------------------------------------------------------------------------
// tone_sequencer
//
// Shares the single tone oscillator between three requesters from the game
// controller: lamp-echo tones, the lose jingle and the high-score jingle.
// Requests are arbitrated by fixed priority (LOSE > HS > LAMP). Each note is
// played for NOTE_TICKS cycles and followed by GAP_TICKS silent cycles.
//
// Sequences:
//   LAMP : {lamp_note}        (1 note, tones 0-3)
//   LOSE : 7, 6, 5, 4         (4 notes)
//   HS   : 4, 5, 6, 7, 7      (5 notes)
//
// Ports:
//   clk        in   game clock (10 kHz divided clock)
//   rst_n      in   asynchronous, active-low reset
//   lamp_req   in   one-cycle request to play lamp tone lamp_note
//   lamp_note  in   lamp index 0-3, sampled only on an accepted lamp_req
//   lose_req   in   one-cycle request to play the lose jingle
//   hs_req     in   one-cycle request to play the high-score jingle
//   mute       in   level; forces osc_en low without changing any timing
//   osc_en     out  oscillator enable (registered)
//   note_sel   out  oscillator note: 0-3 lamp tones, 4-7 jingle tones
//   busy       out  high whenever the sequencer is not idle
//   done       out  one-cycle pulse when a sequence completes normally
// -----------------------------------------------------------------------------
module tone_sequencer #(
    parameter int NOTE_TICKS = 2000,
    parameter int GAP_TICKS  = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lamp_req,
    input  logic [1:0] lamp_note,
    input  logic       lose_req,
    input  logic       hs_req,
    input  logic       mute,
    output logic       osc_en,
    output logic [2:0] note_sel,
    output logic       busy,
    output logic       done
);

    // The tick counter only ever holds TICKS-1, so $clog2 of the larger phase
    // length is enough; keep at least one bit for the degenerate 1/1 case.
    localparam int MAX_TICKS = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
    localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

    localparam logic [CNT_W-1:0] NOTE_LOAD = CNT_W'(NOTE_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_TICKS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic [1:0] KIND_LAMP = 2'd0;
    localparam logic [1:0] KIND_LOSE = 2'd1;
    localparam logic [1:0] KIND_HS   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [1:0]       kind_q, kind_d;
    logic [2:0]       step_q, step_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       lamp_note_q, lamp_note_d;
    logic             osc_en_q, osc_en_d;
    logic [2:0]       note_sel_q, note_sel_d;
    logic             done_q, done_d;

    logic             preemptable;
    logic             take_lose;
    logic             take_hs;
    logic             take_lamp;
    logic             accept;

    // Note played at a given step of a sequence.
    function automatic logic [2:0] seq_note(input logic [1:0] kind,
                                            input logic [2:0] step,
                                            input logic [1:0] lamp);
        logic [2:0] note;
        note = 3'd0;
        case (kind)
            KIND_LAMP: note = {1'b0, lamp};
            KIND_LOSE: note = 3'd7 - step;
            KIND_HS:   note = (step >= 3'd3) ? 3'd7 : (3'd4 + step);
            default:   note = 3'd0;
        endcase
        return note;
    endfunction

    // Index of the final step of a sequence.
    function automatic logic [2:0] seq_last(input logic [1:0] kind);
        logic [2:0] last;
        last = 3'd0;
        case (kind)
            KIND_LAMP: last = 3'd0;
            KIND_LOSE: last = 3'd3;
            KIND_HS:   last = 3'd4;
            default:   last = 3'd0;
        endcase
        return last;
    endfunction

    // Arbitration. LOSE always wins (it preempts everything and restarts
    // itself). HS and LAMP only get in when idle or when a lamp tone is
    // playing. Requests that lose arbitration are simply dropped.
    always_comb begin
        preemptable = (state_q == ST_IDLE) || (kind_q == KIND_LAMP);
        take_lose   = lose_req;
        take_hs     = hs_req && !lose_req && preemptable;
        take_lamp   = lamp_req && !lose_req && !hs_req && preemptable;
        accept      = take_lose || take_hs || take_lamp;
    end

    // Sequencing. An accepted request always restarts at step 0 with a fresh
    // note counter, which also silently discards any preempted sequence (no
    // done pulse for it). Otherwise the down-counter times each PLAY and GAP
    // phase, and the last GAP returns to IDLE with a done pulse.
    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        step_d      = step_q;
        cnt_d       = cnt_q;
        lamp_note_d = lamp_note_q;
        done_d      = 1'b0;

        if (accept) begin
            state_d = ST_PLAY;
            step_d  = 3'd0;
            cnt_d   = NOTE_LOAD;
            if (take_lose) begin
                kind_d = KIND_LOSE;
            end else if (take_hs) begin
                kind_d = KIND_HS;
            end else begin
                kind_d      = KIND_LAMP;
                lamp_note_d = lamp_note;
            end
        end else begin
            case (state_q)
                ST_PLAY: begin
                    if (cnt_q == '0) begin
                        state_d = ST_GAP;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_q == '0) begin
                        if (step_q < seq_last(kind_q)) begin
                            state_d = ST_PLAY;
                            step_d  = step_q + 3'd1;
                            cnt_d   = NOTE_LOAD;
                        end else begin
                            state_d = ST_IDLE;
                            step_d  = 3'd0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    step_d  = 3'd0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output staging. The note is only updated when a note starts; in GAP and
    // IDLE it holds. Mute gates the enable ahead of the register so it never
    // disturbs the phase timing.
    always_comb begin
        note_sel_d = note_sel_q;
        if (state_d == ST_PLAY) begin
            note_sel_d = seq_note(kind_d, step_d, lamp_note_d);
        end
        osc_en_d = (state_d == ST_PLAY) && !mute;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            kind_q      <= KIND_LAMP;
            step_q      <= 3'd0;
            cnt_q       <= '0;
            lamp_note_q <= 2'd0;
            osc_en_q    <= 1'b0;
            note_sel_q  <= 3'd0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            step_q      <= step_d;
            cnt_q       <= cnt_d;
            lamp_note_q <= lamp_note_d;
            osc_en_q    <= osc_en_d;
            note_sel_q  <= note_sel_d;
            done_q      <= done_d;
        end
    end

    assign osc_en   = osc_en_q;
    assign note_sel = note_sel_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;

endmodule
